// File: rtl/msdf_iter_loop_if.sv
// Digit-serial lanes between the iteration controller (master) and an online compute core (slave).
// Each lane carries {last, digit[DW-1:0]}; lane c occupies bits [c*(DW+1) +: DW+1].
interface msdf_iter_loop_if #(
    parameter int CH = 2,
    parameter int DW = 2
);
    logic [CH*(DW+1)-1:0] core_in_digit;
    logic [CH-1:0]        core_in_valid;
    logic [CH-1:0]        core_in_ready;
    logic [CH*(DW+1)-1:0] core_out_digit;
    logic [CH-1:0]        core_out_valid;
    logic [CH-1:0]        core_out_ready;

    modport master (
        output core_in_digit, core_in_valid, core_out_ready,
        input  core_in_ready, core_out_digit, core_out_valid
    );

    modport slave (
        input  core_in_digit, core_in_valid, core_out_ready,
        output core_in_ready, core_out_digit, core_out_valid
    );
endinterface

// File: rtl/msdf_iter_loop.sv
// Iteration-feedback controller for digit-serial MSDF solvers: streams per-channel vectors
// MSD first into a core, captures its outputs and feeds them back for cfg_iters iterations.
module msdf_iter_loop #(
    parameter int CH     = 2,
    parameter int NDIG   = 16,
    parameter int DW     = 2,
    parameter int ITER_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [CH*NDIG*DW-1:0]  init_data,
    input  logic [ITER_W-1:0]      cfg_iters,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ITER_W-1:0]      iter_cnt,
    output logic                   err_overrun,
    output logic [CH*NDIG*DW-1:0]  result_data,
    msdf_iter_loop_if.master       core
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    localparam logic LAST0 = (NDIG == 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, SWAP, FIN} state_t;
    typedef logic [CH-1:0][NDIG-1:0][DW-1:0] vec_t;

    state_t                  state;
    logic [ITER_W-1:0]       iters_q;
    vec_t                    tx_buf;
    vec_t                    rx_buf;
    logic [CH-1:0][IW-1:0]   tx_idx;
    logic [CH-1:0][IW-1:0]   rx_idx;
    logic [CH-1:0][IW-1:0]   tx_nxt;
    logic [CH-1:0][DW:0]     tx_dig;
    logic [CH-1:0][DW:0]     rx_word;
    logic [CH-1:0]           tx_vld, rx_rdy, tx_done, rx_done;
    logic [CH-1:0]           tx_fire, rx_fire, rx_last, rx_final;
    logic                    all_done;

    // Flat layout puts digit 0 (MSD) of each channel in the top DW bits of its slice.
    function automatic vec_t unpack_vec(input logic [CH*NDIG*DW-1:0] flat);
        vec_t v;
        for (int c = 0; c < CH; c++)
            for (int d = 0; d < NDIG; d++)
                v[c][d] = flat[(c*NDIG + NDIG-1-d)*DW +: DW];
        return v;
    endfunction

    function automatic logic [CH*NDIG*DW-1:0] pack_vec(input vec_t v);
        logic [CH*NDIG*DW-1:0] flat;
        flat = '0;
        for (int c = 0; c < CH; c++)
            for (int d = 0; d < NDIG; d++)
                flat[(c*NDIG + NDIG-1-d)*DW +: DW] = v[c][d];
        return flat;
    endfunction

    assign core.core_in_digit  = tx_dig;
    assign core.core_in_valid  = tx_vld;
    assign core.core_out_ready = rx_rdy;
    assign rx_word             = core.core_out_digit;

    // Completion looks at this cycle's handshakes so SWAP follows the final digit directly.
    always_comb begin
        all_done = 1'b1;
        tx_fire  = '0;
        rx_fire  = '0;
        rx_last  = '0;
        rx_final = '0;
        tx_nxt   = '0;
        for (int c = 0; c < CH; c++) begin
            tx_fire[c]  = tx_vld[c] & core.core_in_ready[c];
            rx_fire[c]  = rx_rdy[c] & core.core_out_valid[c];
            rx_last[c]  = rx_word[c][DW];
            rx_final[c] = rx_last[c] || (rx_idx[c] == LAST_IDX);
            tx_nxt[c]   = tx_idx[c] + 1'b1;
            all_done    = all_done
                        & (tx_done[c] | (tx_fire[c] & (tx_idx[c] == LAST_IDX)))
                        & (rx_done[c] | (rx_fire[c] & rx_final[c]));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            iters_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            iter_cnt    <= '0;
            err_overrun <= 1'b0;
            result_data <= '0;
            tx_buf      <= '0;
            rx_buf      <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            tx_dig      <= '0;
            tx_vld      <= '0;
            rx_rdy      <= '0;
            tx_done     <= '0;
            rx_done     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        iters_q     <= cfg_iters;
                        iter_cnt    <= '0;
                        err_overrun <= 1'b0;
                    end
                end
                LOAD: begin
                    tx_buf  <= unpack_vec(init_data);
                    tx_idx  <= '0;
                    rx_idx  <= '0;
                    tx_done <= '0;
                    rx_done <= '0;
                    if (iters_q == '0) begin
                        state <= FIN;
                    end else begin
                        state  <= RUN;
                        tx_vld <= '1;
                        rx_rdy <= '1;
                        for (int c = 0; c < CH; c++)
                            tx_dig[c] <= {LAST0, init_data[(c*NDIG + NDIG-1)*DW +: DW]};
                    end
                end
                RUN: begin
                    for (int c = 0; c < CH; c++) begin
                        if (tx_fire[c]) begin
                            if (tx_idx[c] == LAST_IDX) begin
                                tx_vld[c]  <= 1'b0;
                                tx_done[c] <= 1'b1;
                            end else begin
                                tx_idx[c] <= tx_nxt[c];
                                tx_dig[c] <= {tx_nxt[c] == LAST_IDX, tx_buf[c][tx_nxt[c]]};
                            end
                        end
                        if (rx_fire[c]) begin
                            rx_buf[c][rx_idx[c]] <= rx_word[c][DW-1:0];
                            if (rx_final[c]) begin
                                rx_done[c] <= 1'b1;
                                rx_rdy[c]  <= 1'b0;
                                if (!rx_last[c])
                                    err_overrun <= 1'b1;
                                // Early last: positions after it read as zero.
                                for (int k = 0; k < NDIG; k++)
                                    if (IW'(k) > rx_idx[c])
                                        rx_buf[c][k] <= '0;
                            end else begin
                                rx_idx[c] <= rx_idx[c] + 1'b1;
                            end
                        end
                    end
                    if (all_done)
                        state <= SWAP;
                end
                SWAP: begin
                    tx_buf   <= rx_buf;
                    tx_idx   <= '0;
                    rx_idx   <= '0;
                    tx_done  <= '0;
                    rx_done  <= '0;
                    iter_cnt <= iter_cnt + 1'b1;
                    if ((iter_cnt + 1'b1) < iters_q) begin
                        state  <= RUN;
                        tx_vld <= '1;
                        rx_rdy <= '1;
                        for (int c = 0; c < CH; c++)
                            tx_dig[c] <= {LAST0, rx_buf[c][0]};
                    end else begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result_data <= pack_vec(tx_buf);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msdf_iter_loop.sv
// Directed bench for msdf_iter_loop with a 3-cycle loopback core model that can inject
// early-last, strip last flags, or toggle ready on channel 1.
module tb_msdf_iter_loop;
    localparam int CH = 2, NDIG = 16, DW = 2, ITER_W = 8;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [63:0]           init_data = '0;
    logic [ITER_W-1:0]     cfg_iters = '0;
    logic                  start = 1'b0;
    logic                  busy, done, err_overrun;
    logic [ITER_W-1:0]     iter_cnt;
    logic [63:0]           result_data;

    int total = 0;
    int bad   = 0;

    // core model controls: 0 plain loopback, 1 last forced on ch0 digit 10, 2 last stripped on ch1
    logic [1:0] mode = 2'd0;
    logic       bp   = 1'b0;

    msdf_iter_loop_if #(.CH(CH), .DW(DW)) cif ();

    msdf_iter_loop #(.CH(CH), .NDIG(NDIG), .DW(DW), .ITER_W(ITER_W)) dut (
        .clk(clk), .rstn(rstn), .init_data(init_data), .cfg_iters(cfg_iters),
        .start(start), .busy(busy), .done(done), .iter_cnt(iter_cnt),
        .err_overrun(err_overrun), .result_data(result_data), .core(cif.master)
    );

    always #5 clk = ~clk;

    // ---------------- core model ----------------
    logic [CH-1:0][3:0] st0, st1, st2, st0_n;
    logic [CH-1:0][3:0] in_cnt, cnt_n;
    logic [CH-1:0]      fire_m, last_m;
    logic               tog;

    always_comb begin
        fire_m = '0;
        last_m = '0;
        st0_n  = '0;
        cnt_n  = in_cnt;
        for (int c = 0; c < CH; c++) begin
            fire_m[c] = cif.core_in_valid[c] & cif.core_in_ready[c];
            last_m[c] = cif.core_in_digit[c*3+2];
            if (mode == 2'd1 && c == 0 && in_cnt[c] == 4'd10) last_m[c] = 1'b1;
            if (mode == 2'd2 && c == 1) last_m[c] = 1'b0;
            if (fire_m[c]) begin
                st0_n[c] = {1'b1, last_m[c], cif.core_in_digit[c*3 +: 2]};
                cnt_n[c] = cif.core_in_digit[c*3+2] ? 4'd0 : in_cnt[c] + 4'd1;
            end
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st0 <= '0; st1 <= '0; st2 <= '0; in_cnt <= '0; tog <= 1'b0;
        end else begin
            st0 <= st0_n; st1 <= st0; st2 <= st1; in_cnt <= cnt_n; tog <= ~tog;
        end
    end

    assign cif.core_in_ready  = {bp ? tog : 1'b1, 1'b1};
    assign cif.core_out_valid = {st2[1][3], st2[0][3]};
    assign cif.core_out_digit = {st2[1][2:0], st2[0][2:0]};

    // ---------------- monitors (cumulative) ----------------
    int done_n = 0, busy_n = 0, vld_any = 0;
    int in_hs0 = 0, in_hs1 = 0, out_hs0 = 0, out_hs1 = 0, vld0 = 0, vld1 = 0;

    always @(posedge clk) begin
        if (done) done_n <= done_n + 1;
        if (busy) busy_n <= busy_n + 1;
        if (cif.core_in_valid != 2'b00) vld_any <= vld_any + 1;
        if (cif.core_in_valid[0]) vld0 <= vld0 + 1;
        if (cif.core_in_valid[1]) vld1 <= vld1 + 1;
        if (cif.core_in_valid[0] & cif.core_in_ready[0]) in_hs0 <= in_hs0 + 1;
        if (cif.core_in_valid[1] & cif.core_in_ready[1]) in_hs1 <= in_hs1 + 1;
        if (cif.core_out_valid[0] & cif.core_out_ready[0]) out_hs0 <= out_hs0 + 1;
        if (cif.core_out_valid[1] & cif.core_out_ready[1]) out_hs1 <= out_hs1 + 1;
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] put(input logic [63:0] v, input int c, input int d,
                                        input logic [1:0] x);
        logic [63:0] r;
        r = v;
        r[(c*NDIG + NDIG-1-d)*DW +: DW] = x;
        return r;
    endfunction

    task automatic do_start(input logic [ITER_W-1:0] n, input logic [63:0] v);
        @(negedge clk);
        init_data = v;
        cfg_iters = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", name, max);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (iter_cnt !== 8'd0) begin bad++; $display("FAIL reset_iter: got %0d want 0", iter_cnt); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_overrun); end
        total++; if (result_data !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result_data); end
        total++; if (cif.core_in_valid !== 2'b00) begin bad++; $display("FAIL reset_in_valid: got %b want 00", cif.core_in_valid); end
        total++; if (cif.core_out_ready !== 2'b00) begin bad++; $display("FAIL reset_out_ready: got %b want 00", cif.core_out_ready); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_iters();
        logic [63:0] v;
        int v0, b0;
        v  = 64'h1234_5678_9ABC_DEF0;
        v0 = vld_any;
        b0 = busy_n;
        do_start(8'd0, v);
        // now in cycle t+1 (LOAD)
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_t1: busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_t2: busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_t3: done=%b busy=%b want 1/0", done, busy); end
        total++; if (result_data !== v) begin bad++; $display("FAIL zero_result: got %h want %h", result_data, v); end
        total++; if (iter_cnt !== 8'd0) begin bad++; $display("FAIL zero_iter: got %0d want 0", iter_cnt); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
        total++; if (busy_n - b0 !== 2) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 2", busy_n - b0); end
        total++; if (vld_any - v0 !== 0) begin bad++; $display("FAIL zero_no_valid: got %0d want 0", vld_any - v0); end
    endtask

    task automatic test_loopback();
        logic [63:0] v;
        int d0, b0, i0, i1;
        v  = 64'h0000_0000_4000_0000;
        d0 = done_n; b0 = busy_n; i0 = in_hs0; i1 = in_hs1;
        do_start(8'd3, v);
        total++; if (iter_cnt !== 8'd0) begin bad++; $display("FAIL loop_iter_start: got %0d want 0", iter_cnt); end
        @(negedge clk);
        total++; if (cif.core_in_valid !== 2'b11) begin bad++; $display("FAIL loop_first_valid: got %b want 11", cif.core_in_valid); end
        total++; if (cif.core_in_digit !== 6'b000_001) begin bad++; $display("FAIL loop_first_digit: got %b want 000001", cif.core_in_digit); end
        repeat (8) @(negedge clk);
        // a start during RUN must be ignored
        cfg_iters = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_iters = 8'd3;
        wait_done(400, "loop_done");
        total++; if (iter_cnt !== 8'd3) begin bad++; $display("FAIL loop_iter: got %0d want 3", iter_cnt); end
        total++; if (result_data !== v) begin bad++; $display("FAIL loop_result: got %h want %h", result_data, v); end
        total++; if (busy_n - b0 !== 62) begin bad++; $display("FAIL loop_busy_cycles: got %0d want 62", busy_n - b0); end
        total++; if (in_hs0 - i0 !== 48 || in_hs1 - i1 !== 48) begin bad++; $display("FAIL loop_in_count: got %0d/%0d want 48/48", in_hs0 - i0, in_hs1 - i1); end
        repeat (5) @(negedge clk);
        total++; if (done_n - d0 !== 1) begin bad++; $display("FAIL loop_done_count: got %0d want 1", done_n - d0); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL loop_err: got %b want 0", err_overrun); end
    endtask

    task automatic test_backpressure();
        logic [63:0] v;
        int i1, o1, v0;
        v = 64'h0;
        for (int d = 0; d < NDIG; d++) begin
            v = put(v, 0, d, 2'(d));
            v = put(v, 1, d, 2'(3 - (d % 4)));
        end
        i1 = in_hs1; o1 = out_hs1; v0 = vld0;
        bp = 1'b1;
        do_start(8'd2, v);
        wait_done(600, "bp_done");
        bp = 1'b0;
        total++; if (result_data !== v) begin bad++; $display("FAIL bp_result: got %h want %h", result_data, v); end
        total++; if (iter_cnt !== 8'd2) begin bad++; $display("FAIL bp_iter: got %0d want 2", iter_cnt); end
        total++; if (in_hs1 - i1 !== 32 || out_hs1 - o1 !== 32) begin bad++; $display("FAIL bp_ch1_count: got in=%0d out=%0d want 32/32", in_hs1 - i1, out_hs1 - o1); end
        total++; if (vld0 - v0 !== 32) begin bad++; $display("FAIL bp_ch0_idle: got %0d valid cycles want 32", vld0 - v0); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL bp_err: got %b want 0", err_overrun); end
    endtask

    task automatic test_early_last();
        logic [63:0] v, exp;
        v = 64'h0;
        for (int d = 0; d < NDIG; d++) begin
            v = put(v, 0, d, 2'b10);
            v = put(v, 1, d, 2'(d));
        end
        exp = v;
        for (int d = 11; d < NDIG; d++) exp = put(exp, 0, d, 2'b00);
        mode = 2'd1;
        do_start(8'd1, v);
        wait_done(300, "early_done");
        mode = 2'd0;
        total++; if (result_data !== exp) begin bad++; $display("FAIL early_result: got %h want %h", result_data, exp); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL early_err: got %b want 0", err_overrun); end
        total++; if (iter_cnt !== 8'd1) begin bad++; $display("FAIL early_iter: got %0d want 1", iter_cnt); end
    endtask

    task automatic test_missing_last();
        logic [63:0] v;
        int o1;
        bit seen;
        v  = 64'hA5A5_5A5A_0F0F_F0F0;
        o1 = out_hs1;
        mode = 2'd2;
        do_start(8'd1, v);
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL nolast_err_early: got %b want 0", err_overrun); end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_hs1 - o1 == 16) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL nolast_16th: got %0d handshakes want 16", out_hs1 - o1); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL nolast_err: got %b want 1", err_overrun); end
        total++; if (cif.core_out_ready[1] !== 1'b0) begin bad++; $display("FAIL nolast_ready: got %b want 0", cif.core_out_ready[1]); end
        wait_done(200, "nolast_done");
        mode = 2'd0;
        total++; if (result_data !== v) begin bad++; $display("FAIL nolast_result: got %h want %h", result_data, v); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL nolast_err_sticky: got %b want 1", err_overrun); end
    endtask

    task automatic test_restart_clears();
        logic [63:0] v;
        v = 64'h0000_0001_8000_0000;
        do_start(8'd1, v);
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL restart_err: got %b want 0", err_overrun); end
        wait_done(200, "restart_done");
        total++; if (result_data !== v) begin bad++; $display("FAIL restart_result: got %h want %h", result_data, v); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] v;
        int d0;
        bit seen;
        v = 64'hDEAD_BEEF_0123_4567;
        do_start(8'd3, v);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (iter_cnt == 8'd1) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_reach_iter2: iter_cnt=%0d want 1", iter_cnt); end
        repeat (5) @(negedge clk);
        d0 = done_n;
        #2 rstn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || iter_cnt !== 8'd0) begin bad++; $display("FAIL mid_async_clear: busy=%b iter=%0d want 0/0", busy, iter_cnt); end
        total++; if (cif.core_in_valid !== 2'b00 || cif.core_out_ready !== 2'b00) begin bad++; $display("FAIL mid_async_lanes: valid=%b ready=%b want 00/00", cif.core_in_valid, cif.core_out_ready); end
        total++; if (result_data !== 64'd0) begin bad++; $display("FAIL mid_async_result: got %h want 0", result_data); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done_n - d0 !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", done_n - d0); end
        v = 64'h0123_4567_89AB_CDEF;
        do_start(8'd2, v);
        total++; if (iter_cnt !== 8'd0 || err_overrun !== 1'b0) begin bad++; $display("FAIL mid_fresh_start: iter=%0d err=%b want 0/0", iter_cnt, err_overrun); end
        wait_done(300, "mid_fresh_done");
        total++; if (iter_cnt !== 8'd2) begin bad++; $display("FAIL mid_fresh_iter: got %0d want 2", iter_cnt); end
        total++; if (result_data !== v) begin bad++; $display("FAIL mid_fresh_result: got %h want %h", result_data, v); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL mid_fresh_err: got %b want 0", err_overrun); end
    endtask

    initial begin
        test_reset();
        test_zero_iters();
        test_loopback();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_restart_clears();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
